// File: rtl/m_bus_arbiter_pkg.sv
// Shared definitions for the two-requester bus arbiter.
//   state_e      : FSM encoding (IDLE, GRANT0, GRANT1, TURN)
//   CH_0 / CH_1  : mux/demux select values
//   arbitrate()  : picks the next state from the request pair and priority pointer
package m_bus_arbiter_pkg;

   localparam int unsigned DEF_MAX_HOLD = 16;
   localparam int unsigned DEF_CNT_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10,
      ST_TURN   = 2'b11
   } state_e;

   localparam logic CH_0 = 1'b0;
   localparam logic CH_1 = 1'b1;

   // A tie goes to the requester named by the pointer.
   function automatic state_e arbitrate(input logic req_0, input logic req_1, input logic ptr);
      state_e nxt;
      nxt = ST_IDLE;
      if (req_0 && req_1) nxt = ptr ? ST_GRANT1 : ST_GRANT0;
      else if (req_0)     nxt = ST_GRANT0;
      else if (req_1)     nxt = ST_GRANT1;
      return nxt;
   endfunction

endpackage

// File: rtl/m_bus_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
//   w_req_0/1      : requests (requester -> arbiter)
//   w_grant_0/1    : grants (arbiter -> requester)
//   w_channel      : mux/demux select
//   w_bus_enable   : bus-valid qualifier
//   w_hold_count   : tenure of the current owner (debug)
interface m_bus_arbiter_if
   import m_bus_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic             w_req_0;
   logic             w_req_1;
   logic             w_grant_0;
   logic             w_grant_1;
   logic             w_channel;
   logic             w_bus_enable;
   logic [CNT_W-1:0] w_hold_count;

   // Requester side.
   modport master (
      output w_req_0, w_req_1,
      input  w_grant_0, w_grant_1, w_channel, w_bus_enable, w_hold_count
   );

   // Arbiter side.
   modport slave (
      input  w_req_0, w_req_1,
      output w_grant_0, w_grant_1, w_channel, w_bus_enable, w_hold_count
   );

endinterface

// File: rtl/m_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   w_clock, w_reset : clock, async active-low reset
//   clr_i            : synchronous clear (wins over inc_i)
//   inc_i            : increment, holds at MAX
//   count_o          : current count
module m_sat_counter
   import m_bus_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned MAX   = DEF_MAX_HOLD
) (
   input  logic             w_clock,
   input  logic             w_reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear, increment, or hold at saturation.
   always_comb begin
      count_d = count_q;
      if (clr_i)                         count_d = '0;
      else if (inc_i && count_q != MAX_C) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge w_clock or negedge w_reset) begin
      if (!w_reset) count_q <= '0;
      else          count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/m_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing the 8-bit mux/demux bus.
// A one-cycle TURN gap separates every change of owner; tenure is capped at
// MAX_HOLD cycles when the other side is waiting.
//   w_clock, w_reset : clock, async active-low reset
//   bus              : request/grant bundle (slave modport)
module m_bus_arbiter
   import m_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic            w_clock,
   input  logic            w_reset,
   m_bus_arbiter_if.slave  bus
);

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             grant0_q, grant0_d;
   logic             grant1_q, grant1_d;
   logic             chan_q, chan_d;
   logic             en_q, en_d;
   logic             hold_clr, hold_inc;
   logic             hold_at_max;
   logic [CNT_W-1:0] hold_cnt;

   assign hold_at_max = (hold_cnt == CNT_W'(MAX_HOLD));

   // Next state, pointer and registered-output precompute.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      chan_d   = chan_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      en_d     = 1'b0;
      hold_inc = 1'b0;
      hold_clr = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_TURN: state_d = arbitrate(bus.w_req_0, bus.w_req_1, ptr_q);
         ST_GRANT0: begin
            // Release and preemption collapse into one move to TURN.
            if (!bus.w_req_0 || (hold_at_max && bus.w_req_1)) begin
               state_d = ST_TURN;
               ptr_d   = 1'b1;
            end
         end
         ST_GRANT1: begin
            if (!bus.w_req_1 || (hold_at_max && bus.w_req_0)) begin
               state_d = ST_TURN;
               ptr_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      grant0_d = (state_d == ST_GRANT0);
      grant1_d = (state_d == ST_GRANT1);
      en_d     = grant0_d | grant1_d;
      hold_inc = en_d;
      hold_clr = !en_d;

      // Select moves only on entry to a grant; it parks during IDLE/TURN.
      if (grant0_d)      chan_d = CH_0;
      else if (grant1_d) chan_d = CH_1;
   end

   always_ff @(posedge w_clock or negedge w_reset) begin
      if (!w_reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b0;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         chan_q   <= CH_0;
         en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         chan_q   <= chan_d;
         en_q     <= en_d;
      end
   end

   // Tenure counter: 1 in the first grant cycle, cleared outside grants.
   m_sat_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_HOLD)
   ) u_hold (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .clr_i   (hold_clr),
      .inc_i   (hold_inc),
      .count_o (hold_cnt)
   );

   assign bus.w_grant_0    = grant0_q;
   assign bus.w_grant_1    = grant1_q;
   assign bus.w_channel    = chan_q;
   assign bus.w_bus_enable = en_q;
   assign bus.w_hold_count = hold_cnt;

endmodule

// File: tb/tb_m_bus_arbiter.sv
// Bench for m_bus_arbiter: two instances (MAX_HOLD 4 and 16) share one
// request stream and are compared against an ownership-level model.
module tb_m_bus_arbiter;

   logic w_clock;
   logic w_reset;
   logic req0;
   logic req1;

   int checks = 0;
   int errors = 0;

   m_bus_arbiter_if #(.CNT_W(5)) ifa ();
   m_bus_arbiter_if #(.CNT_W(5)) ifb ();

   assign ifa.w_req_0 = req0;
   assign ifa.w_req_1 = req1;
   assign ifb.w_req_0 = req0;
   assign ifb.w_req_1 = req1;

   m_bus_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut_a (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .bus     (ifa)
   );

   m_bus_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut_b (
      .w_clock (w_clock),
      .w_reset (w_reset),
      .bus     (ifb)
   );

   initial w_clock = 1'b0;
   always #5 w_clock = ~w_clock;

   // Model: owner -1 means nobody (IDLE or the TURN gap).
   int m_max   [2] = '{4, 16};
   int m_owner [2];
   int m_ptr   [2];
   int m_hold  [2];
   int m_chan  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1;
         m_ptr[i]   = 0;
         m_hold[i]  = 0;
         m_chan[i]  = 0;
      end
   endtask

   task automatic model_step(input int i, input logic r0, input logic r1);
      int   n;
      int   win;
      logic mine;
      logic other;
      if (m_owner[i] >= 0) begin
         n     = m_owner[i];
         mine  = (n == 0) ? r0 : r1;
         other = (n == 0) ? r1 : r0;
         if (!mine || (m_hold[i] == m_max[i] && other)) begin
            m_owner[i] = -1;
            m_ptr[i]   = 1 - n;
            m_hold[i]  = 0;
         end else if (m_hold[i] < m_max[i]) begin
            m_hold[i]++;
         end
      end else begin
         win = -1;
         if (r0 && r1) win = m_ptr[i];
         else if (r0)  win = 0;
         else if (r1)  win = 1;
         if (win >= 0) begin
            m_owner[i] = win;
            m_hold[i]  = 1;
            m_chan[i]  = win;
         end
      end
   endtask

   task automatic cmp(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s inst%0d observed %0h expected %0h", tag, i, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input string tag);
      logic       g0, g1, ch, en;
      logic [4:0] hc;
      if (i == 0) begin
         g0 = ifa.w_grant_0; g1 = ifa.w_grant_1; ch = ifa.w_channel;
         en = ifa.w_bus_enable; hc = ifa.w_hold_count;
      end else begin
         g0 = ifb.w_grant_0; g1 = ifb.w_grant_1; ch = ifb.w_channel;
         en = ifb.w_bus_enable; hc = ifb.w_hold_count;
      end
      cmp({tag, ".grant_0"}, i, 8'(g0), 8'(m_owner[i] == 0));
      cmp({tag, ".grant_1"}, i, 8'(g1), 8'(m_owner[i] == 1));
      cmp({tag, ".channel"}, i, 8'(ch), 8'(m_chan[i]));
      cmp({tag, ".hold"},    i, 8'(hc), 8'(m_hold[i]));
      cmp({tag, ".enable"},  i, 8'(en), 8'(m_owner[i] >= 0));
      cmp({tag, ".excl"},    i, 8'(g0 & g1), 8'(0));
      cmp({tag, ".en_or"},   i, 8'(en), 8'(g0 | g1));
   endtask

   task automatic tick(input string tag);
      @(posedge w_clock);
      for (int i = 0; i < 2; i++) model_step(i, req0, req1);
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   // Reset held across one edge, released away from the edge.
   task automatic do_reset(input logic r0, input logic r1);
      w_reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, "reset");
      @(posedge w_clock);
      #1;
      req0 = r0;
      req1 = r1;
      w_reset = 1'b1;
   endtask

   initial begin
      w_reset = 1'b1;
      req0    = 1'b0;
      req1    = 1'b0;
      model_reset();
      #2;

      // 1: single requester, count 1,2,3, release through TURN to IDLE.
      do_reset(1'b1, 1'b0);
      ticks(3, "t1_grant");
      req0 = 1'b0;
      ticks(3, "t1_release");

      // 2: simultaneous requests, pointer 0 wins; handover after release.
      do_reset(1'b1, 1'b1);
      ticks(3, "t2_grant0");
      req0 = 1'b0;
      ticks(4, "t2_handover");

      // 3: both held, alternation every MAX_HOLD cycles with a gap.
      do_reset(1'b1, 1'b1);
      ticks(24, "t3_alternate");

      // 4: lone requester saturates, then preemption once the other arrives.
      do_reset(1'b0, 1'b1);
      ticks(30, "t4_saturate");
      req0 = 1'b1;
      ticks(6, "t4_preempt");

      // 5: asynchronous reset in the middle of a GRANT1 tenure.
      req0 = 1'b0;
      req1 = 1'b1;
      ticks(3, "t5_grant1");
      #3;
      w_reset = 1'b0;
      #1;
      cmp("t5_async.grant_1", 1, 8'(ifb.w_grant_1), 8'(0));
      cmp("t5_async.enable",  0, 8'(ifa.w_bus_enable), 8'(0));
      cmp("t5_async.channel", 0, 8'(ifa.w_channel), 8'(0));
      cmp("t5_async.hold",    1, 8'(ifb.w_hold_count), 8'(0));
      do_reset(1'b1, 1'b1);
      ticks(3, "t5_after");

      // 6: owner drops its request on the very edge preemption fires.
      do_reset(1'b1, 1'b1);
      ticks(4, "t6_hold");
      req0 = 1'b0;
      ticks(3, "t6_collide");

      // Random request traffic with some persistence.
      req0 = 1'b0;
      req1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(3, 0) == 0) req0 = ~req0;
         if ($urandom_range(3, 0) == 0) req1 = ~req1;
         tick("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
